// File: rtl/sobel_linebuf_if.sv
// Pixel-in / triplet-out handshake bundle for sobel_linebuf.
// slave is the line buffer's view; master is the producer/consumer side.
interface sobel_linebuf_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pix_in;
  logic             pix_in_vld;
  logic             pix_in_rdy;
  logic [PIX_W-1:0] input_row_a00;
  logic [PIX_W-1:0] input_row_a01;
  logic [PIX_W-1:0] input_row_a02;
  logic             row_vld;
  logic             row_rdy;
  logic             frame_done;

  modport slave (
    input  pix_in, pix_in_vld, row_rdy,
    output pix_in_rdy, input_row_a00, input_row_a01, input_row_a02,
           row_vld, frame_done
  );

  modport master (
    output pix_in, pix_in_vld, row_rdy,
    input  pix_in_rdy, input_row_a00, input_row_a01, input_row_a02,
           row_vld, frame_done
  );
endinterface

// File: rtl/sobel_linebuf.sv
// Two-line buffer producing vertical 3-pixel columns for a Sobel core.
// Define SOBEL_LINEBUF_BORDER_EN to also emit rows 0/1 with top-border replication.
//
// state  | meaning
// FILL   | rows 0..1, priming the line memories
// STREAM | rows 2..IMG_H-1, one triplet per accepted pixel
// FLUSH  | last pixel taken, waiting for the final triplet handshake
module sobel_linebuf #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input logic             CLOCK,
  input logic             RESET,
  sobel_linebuf_if.slave  bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [PIX_W-1:0] line0_q [IMG_W];
  logic [PIX_W-1:0] line1_q [IMG_W];
  logic [PIX_W-1:0] a00_q, a01_q, a02_q;
  logic [PIX_W-1:0] a00_d, a01_d, a02_d;
  logic             row_vld_q;
  logic             frame_done_q;

  logic             in_rdy;
  logic             xfer;
  logic             emit;
  logic             col_last;
  logic             row_last;
  logic [PIX_W-1:0] up2, up1;

  assign up2 = line0_q[col_q];
  assign up1 = line1_q[col_q];

  always_comb begin
    in_rdy   = (!row_vld_q || bus.row_rdy) && (state_q != FLUSH);
    xfer     = bus.pix_in_vld && in_rdy;
    col_last = (col_q == COL_W'(IMG_W - 1));
    row_last = (row_q == ROW_W'(IMG_H - 1));
`ifdef SOBEL_LINEBUF_BORDER_EN
    emit = xfer;
    if (row_q == ROW_W'(0)) begin
      a00_d = bus.pix_in;
      a01_d = bus.pix_in;
      a02_d = bus.pix_in;
    end else if (row_q == ROW_W'(1)) begin
      a00_d = up1;
      a01_d = up1;
      a02_d = bus.pix_in;
    end else begin
      a00_d = up2;
      a01_d = up1;
      a02_d = bus.pix_in;
    end
`else
    emit  = xfer && (state_q == STREAM);
    a00_d = up2;
    a01_d = up1;
    a02_d = bus.pix_in;
`endif
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      a00_q        <= '0;
      a01_q        <= '0;
      a02_q        <= '0;
      row_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (emit) begin
        a00_q     <= a00_d;
        a01_q     <= a01_d;
        a02_q     <= a02_d;
        row_vld_q <= 1'b1;
      end else if (bus.row_rdy) begin
        row_vld_q <= 1'b0;
      end

      case (state_q)
        FILL, STREAM: begin
          if (xfer) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q   <= '0;
                state_q <= FLUSH;
              end else begin
                row_q   <= row_q + 1'b1;
                // row_q+1 >= 2 means the next line already has two lines above it
                state_q <= (row_q >= ROW_W'(1)) ? STREAM : FILL;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (row_vld_q && bus.row_rdy) begin
            frame_done_q <= 1'b1;
            state_q      <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Line memories are not reset; every triplet reads columns rewritten in this frame.
  always_ff @(posedge CLOCK) begin
    if (xfer && !RESET) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= bus.pix_in;
    end
  end

  assign bus.pix_in_rdy    = in_rdy;
  assign bus.input_row_a00 = a00_q;
  assign bus.input_row_a01 = a01_q;
  assign bus.input_row_a02 = a02_q;
  assign bus.row_vld       = row_vld_q;
  assign bus.frame_done    = frame_done_q;
endmodule

// File: tb/tb_sobel_linebuf.sv
// Self-checking bench for sobel_linebuf: randomized handshakes against an image-array model.
module tb_sobel_linebuf;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
`ifdef SOBEL_LINEBUF_BORDER_EN
  localparam bit          BORDER     = 1'b1;
  localparam int          TPF        = H * W;
  localparam logic [23:0] FIRST_TRIP = 24'h000000;
  localparam int          HOLD_IDX   = 0;
`else
  localparam bit          BORDER     = 1'b0;
  localparam int          TPF        = (H - 2) * W;
  localparam logic [23:0] FIRST_TRIP = 24'h001020;
  localparam int          HOLD_IDX   = 2 * W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_linebuf_if #(.PIX_W(PW)) bus ();

  sobel_linebuf #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  img[H][W];
  int          m_row, m_col;
  bit          m_flush;
  int          trip_cnt, fd_cnt;
  bit          hold_prev;
  logic [23:0] hold_val;
  bit          rst_pend;
  bit          acc_last;
  bit          rdy_rand, rdy_hold, vld_rand;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a triplet is the column through the stored image, clamped at the top edge.
  task automatic model_accept(input logic [7:0] p);
    int r2, r1;
    img[m_row][m_col] = p;
    if (BORDER || m_row >= 2) begin
      r2 = (m_row >= 2) ? m_row - 2 : 0;
      r1 = (m_row >= 1) ? m_row - 1 : 0;
      exp_q.push_back({img[r2][m_col], img[r1][m_col], p});
    end
    if (m_col == W - 1) begin
      m_col = 0;
      if (m_row == H - 1) begin
        m_row   = 0;
        m_flush = 1'b1;
      end else begin
        m_row++;
      end
    end else begin
      m_col++;
    end
  endtask

  task automatic tick();
    logic [23:0] trip;
    logic [23:0] e;
    @(negedge clk);
    trip     = {bus.input_row_a00, bus.input_row_a01, bus.input_row_a02};
    acc_last = 1'b0;
    if (rst_pend) begin
      chk("rst_row_vld", 32'(bus.row_vld), 32'(0));
      chk("rst_frame_done", 32'(bus.frame_done), 32'(0));
    end
    if (!rst) begin
      if (bus.frame_done) begin
        fd_cnt++;
        chk("trips_per_frame", 32'(trip_cnt), 32'(TPF));
        trip_cnt = 0;
        m_flush  = 1'b0;
      end
      if (hold_prev) begin
        chk("hold_vld", 32'(bus.row_vld), 32'(1));
        chk("hold_data", 32'(trip), 32'(hold_val));
      end
      chk("pix_in_rdy", 32'(bus.pix_in_rdy),
          32'((!bus.row_vld || bus.row_rdy) && !m_flush));
      if (bus.row_vld && bus.row_rdy) begin
        if (exp_q.size() == 0) begin
          chk("triplet_expected", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          chk("triplet", 32'(trip), 32'(e));
          trip_cnt++;
        end
      end
      if (bus.pix_in_vld && bus.pix_in_rdy) begin
        model_accept(bus.pix_in);
        acc_last = 1'b1;
      end
      hold_prev = bus.row_vld && !bus.row_rdy;
      hold_val  = trip;
    end else begin
      hold_prev = 1'b0;
    end
    rst_pend = rst;
    @(posedge clk);
    #1;
    bus.row_rdy = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic send_pixel(input logic [7:0] p);
    int budget = 0;
    bus.pix_in = p;
    do begin
      bus.pix_in_vld = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget++;
    end while (!acc_last && budget < 200);
    if (!acc_last) chk("pix_accept_timeout", 32'(acc_last), 32'(1));
    bus.pix_in_vld = 1'b0;
  endtask

  task automatic do_hold();
    logic [23:0] trip;
    rdy_hold       = 1'b1;
    bus.row_rdy    = 1'b0;
    bus.pix_in_vld = 1'b1;
    bus.pix_in     = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      trip = {bus.input_row_a00, bus.input_row_a01, bus.input_row_a02};
      chk("hold_first_trip", 32'(trip), 32'(FIRST_TRIP));
      chk("hold_pix_in_rdy", 32'(bus.pix_in_rdy), 32'(0));
    end
    rdy_hold       = 1'b0;
    bus.row_rdy    = 1'b1;
    bus.pix_in_vld = 1'b0;
  endtask

  task automatic send_frame(input bit rand_pix, input int hold_at);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pixel(rand_pix ? 8'($urandom_range(0, 255)) : 8'(16 * r + c));
        if (r * W + c == hold_at) do_hold();
      end
    end
  endtask

  task automatic wait_done(input int target);
    int budget = 0;
    bus.pix_in_vld = 1'b0;
    while (fd_cnt < target && budget < 200) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    chk("frame_done_count", 32'(fd_cnt), 32'(target));
  endtask

  initial begin
    rst            = 1'b1;
    bus.pix_in     = '0;
    bus.pix_in_vld = 1'b0;
    bus.row_rdy    = 1'b1;
    m_row = 0; m_col = 0; m_flush = 1'b0;
    trip_cnt = 0; fd_cnt = 0;
    hold_prev = 1'b0; rst_pend = 1'b0;
    rdy_rand = 1'b0; rdy_hold = 1'b0; vld_rand = 1'b0;

    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("reset_a00", 32'(bus.input_row_a00), 32'(0));
    chk("reset_a01", 32'(bus.input_row_a01), 32'(0));
    chk("reset_a02", 32'(bus.input_row_a02), 32'(0));
    chk("reset_row_vld", 32'(bus.row_vld), 32'(0));
    chk("reset_pix_in_rdy", 32'(bus.pix_in_rdy), 32'(1));

    // full frame, always ready
    send_frame(1'b0, -1);
    wait_done(1);

    // consumer stalls on the first triplet
    send_frame(1'b0, HOLD_IDX);
    wait_done(2);

    // bursty producer
    vld_rand = 1'b1;
    send_frame(1'b0, -1);
    vld_rand = 1'b0;
    wait_done(3);

    // reset mid-frame abandons it
    for (int i = 0; i < 6; i++) send_pixel(8'(16 * (i / W) + (i % W)));
    rst            = 1'b1;
    bus.pix_in_vld = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    m_row = 0; m_col = 0; m_flush = 1'b0; trip_cnt = 0;
    tick();
    send_frame(1'b0, -1);
    wait_done(4);

    // back-to-back random frames
    send_frame(1'b1, -1);
    send_frame(1'b1, -1);
    wait_done(6);

    // random data with random handshakes on both sides
    rdy_rand = 1'b1;
    vld_rand = 1'b1;
    repeat (3) send_frame(1'b1, -1);
    rdy_rand = 1'b0;
    vld_rand = 1'b0;
    bus.row_rdy = 1'b1;
    wait_done(9);

    chk("leftover_triplets", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sobel_linebuf.md
SOBEL_LINEBUF -- requirements
Module: sobel_linebuf

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per line (range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 64, lines per frame (range 3..1024).
REQ-003 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-004 SHALL have port CLOCK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pix_in, input, PIX_W bits: raster-order pixel, row-major, top line first.
REQ-007 SHALL have port pix_in_vld, input, 1 bit: pix_in is valid.
REQ-008 SHALL have port pix_in_rdy, output, 1 bit: the block accepts pix_in this cycle.
REQ-009 SHALL have port input_row_a00, output, PIX_W bits: the pixel in line r-2 at the current column.
REQ-010 SHALL have port input_row_a01, output, PIX_W bits: the pixel in line r-1 at the current column.
REQ-011 SHALL have port input_row_a02, output, PIX_W bits: the pixel in line r at the current column.
REQ-012 SHALL have port row_vld, output, 1 bit: the triplet on input_row_a00..a02 is valid.
REQ-013 SHALL have port row_rdy, input, 1 bit: the sobel core accepts the triplet.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last triplet of a frame is accepted.

Function
REQ-015 SHALL hold two line memories of IMG_W x PIX_W, plus column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1).
REQ-016 SHALL drive pix_in_rdy = !row_vld || row_rdy, so the output stage is a single register with no skid buffer.
REQ-017 SHALL treat a cycle with pix_in_vld && pix_in_rdy as an input transfer; other cycles change no counter or memory.
REQ-018 On an input transfer, SHALL shift the column: line1[col] moves to line0[col], and pix_in is written to line1[col].
REQ-019 On an input transfer in row >= 2, SHALL register {a00, a01, a02} = {line0[col], line1[col], pix_in} and set row_vld the next cycle (1-cycle latency).
REQ-020 SHALL keep the triplet and row_vld stable while row_vld && !row_rdy.
REQ-021 SHALL clear row_vld after a cycle with row_vld && row_rdy and no new triplet; a simultaneous new transfer reloads the register back-to-back.
REQ-022 SHALL implement states FILL (row < 2), STREAM (row >= 2) and FLUSH (last pixel accepted, waiting for the last triplet handshake).
REQ-023 Col SHALL wrap from IMG_W-1 to 0 and increment row; row SHALL wrap from IMG_H-1 to 0 and enter FLUSH.
REQ-024 In FLUSH, SHALL hold pix_in_rdy = 0; when the final triplet handshakes, pulse frame_done for one cycle and return to FILL.
REQ-025 SHALL produce exactly (IMG_H-2)*IMG_W triplets per frame, in raster order.

Reset
REQ-026 While RESET = 1 at a clock edge, SHALL clear col, row, row_vld, frame_done and input_row_a00..a02 to 0, and set the state to FILL.
REQ-027 Line memory contents SHALL NOT be reset; REQ-018 guarantees that no triplet uses stale data.
REQ-028 RESET mid-frame SHALL abandon the frame; the next accepted pixel is treated as row 0, col 0.

Configuration
REQ-029 With macro SOBEL_LINEBUF_BORDER_EN defined, SHALL also emit triplets in rows 0 and 1 with top-border replication:
- row 0: {p, p, p}
- row 1: {line1, line1, p}
- total IMG_H*IMG_W triplets per frame
REQ-030 Without SOBEL_LINEBUF_BORDER_EN, rows 0 and 1 SHALL emit nothing, as in REQ-019 and REQ-025.

Verification
Unless stated, benches use IMG_W=4, IMG_H=4, pixel value 16*r+c.
REQ-031 Stream the full frame with row_rdy=1 -> 8 triplets; first = {0x00,0x10,0x20}; r=2,c=1 gives {0x01,0x11,0x21}; last = {0x13,0x23,0x33}; frame_done pulses once.
REQ-032 Hold row_rdy=0 for 5 cycles at the first triplet -> triplet stays {0x00,0x10,0x20}, pix_in_rdy=0, and no data is lost afterward.
REQ-033 Toggle pix_in_vld randomly at 50% -> the triplet sequence is identical to REQ-031.
REQ-034 Assert RESET after 6 pixels, then send a full frame -> row_vld=0 during reset and output is identical to REQ-031.
REQ-035 Send two frames back-to-back -> the second frame yields 8 triplets with no cross-frame mixing, and two frame_done pulses.
REQ-036 Build with SOBEL_LINEBUF_BORDER_EN -> 16 triplets; first = {0x00,0x00,0x00}; r=1,c=2 gives {0x02,0x02,0x12}.
